// File: rtl/divremsqrt_iter_fsm_if.sv
// ============================================================================
// Module      : divremsqrt_iter_fsm_if
// Description : Request/status bundle between the pipeline, the divide/sqrt
//               preprocessor and the iteration sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface divremsqrt_iter_fsm_if #(
  parameter int DURLEN = 4
);
  logic              FDivStartE;
  logic              IDivStartE;
  logic              StallM;
  logic              FlushE;
  logic              IntDivE;
  logic              FPSpecialCaseE;
  logic              ISpecialCaseE;
  logic [DURLEN:0]   CyclesE;
  logic              IFDivStartE;
  logic              FDivBusyE;
  logic              IterEnM;
  logic              FirstIterM;
  logic              FDivDoneE;
  logic              SpecialCaseM;
  logic [DURLEN:0]   StepM;

  modport master (
    output FDivStartE, IDivStartE, StallM, FlushE, IntDivE,
           FPSpecialCaseE, ISpecialCaseE, CyclesE,
    input  IFDivStartE, FDivBusyE, IterEnM, FirstIterM, FDivDoneE,
           SpecialCaseM, StepM
  );

  modport slave (
    input  FDivStartE, IDivStartE, StallM, FlushE, IntDivE,
           FPSpecialCaseE, ISpecialCaseE, CyclesE,
    output IFDivStartE, FDivBusyE, IterEnM, FirstIterM, FDivDoneE,
           SpecialCaseM, StepM
  );
endinterface

`default_nettype wire

// File: rtl/divremsqrt_iter_fsm.sv
// ============================================================================
// Module      : divremsqrt_iter_fsm
// Description : Sequencer for the iterative div/rem/sqrt unit: accepts a
//               start, counts CyclesE iterations, then signals done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divremsqrt_iter_fsm #(
  parameter int DURLEN      = 4,
  parameter bit IDIV_ON_FPU = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  divremsqrt_iter_fsm_if.slave  bus
);

  localparam int                c_cntW    = DURLEN + 1;
  localparam logic [c_cntW-1:0] c_stepOne = c_cntW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_cntW-1:0]   r_step;
  logic                r_specialCase;
  logic                r_iterEn;
  logic                r_firstIter;
  logic                r_done;

  logic                w_iDivStart;
  logic                w_start;
  logic                w_specEff;

  // Integer requests only reach this unit when integer divide shares the FPU.
  generate
    if (IDIV_ON_FPU) begin : g_idivOn
      assign w_iDivStart = bus.IDivStartE;
    end else begin : g_idivOff
      assign w_iDivStart = 1'b0;
    end
  endgenerate

  assign w_start   = (bus.FDivStartE | w_iDivStart) & (r_state == S_IDLE)
                   & ~bus.StallM & ~bus.FlushE;
  assign w_specEff = bus.IntDivE ? bus.ISpecialCaseE : bus.FPSpecialCaseE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_step        <= '0;
      r_specialCase <= 1'b0;
      r_iterEn      <= 1'b0;
      r_firstIter   <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_firstIter <= 1'b0;
      if (bus.FlushE) begin
        r_state  <= S_IDLE;
        r_step   <= '0;
        r_iterEn <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_specialCase <= w_specEff;
              if (w_specEff) begin
                r_state <= S_DONE;
                r_step  <= '0;
                r_done  <= 1'b1;
              end else begin
                // A zero count still costs one iteration.
                r_state     <= S_BUSY;
                r_step      <= (bus.CyclesE == '0) ? c_stepOne : bus.CyclesE;
                r_iterEn    <= 1'b1;
                r_firstIter <= 1'b1;
              end
            end
          end
          S_BUSY: begin
            if (r_step <= c_stepOne) begin
              r_state  <= S_DONE;
              r_step   <= '0;
              r_iterEn <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_step <= r_step - c_stepOne;
            end
          end
          S_DONE: begin
            if (!bus.StallM) begin
              r_state <= S_IDLE;
              r_done  <= 1'b0;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_iterEn <= 1'b0;
            r_done   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Busy is asserted in the start cycle itself so Execute freezes at once.
  assign bus.IFDivStartE  = w_start;
  assign bus.FDivBusyE    = w_start | (r_state == S_BUSY)
                          | ((r_state == S_DONE) & bus.StallM);
  assign bus.IterEnM      = r_iterEn;
  assign bus.FirstIterM   = r_firstIter;
  assign bus.FDivDoneE    = r_done;
  assign bus.SpecialCaseM = r_specialCase;
  assign bus.StepM        = r_step;

endmodule

`default_nettype wire
